// File: rtl/sw_pe_affine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_pe_affine_if : systolic PE bus (query chain, T beat, config, out)   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface sw_pe_affine_if #(
  parameter int SW   = 12,
  parameter int CW   = 2,
  parameter int IDXW = 10
);
  logic                   i_cfg_local;
  logic        [SW-1:0]   i_cfg_alpha;
  logic        [SW-1:0]   i_cfg_beta;
  logic                   i_load_s;
  logic        [CW-1:0]   i_s_in;
  logic        [CW-1:0]   o_s_out;
  logic                   o_load_s_out;
  logic                   i_valid_in;
  logic                   i_first_in;
  logic        [CW-1:0]   i_t_in;
  logic signed [SW-1:0]   i_v_in;
  logic signed [SW-1:0]   i_f_in;
  logic signed [SW-1:0]   i_max_in;
  logic        [IDXW-1:0] i_maxidx_in;
  logic                   o_valid_out;
  logic                   o_first_out;
  logic        [CW-1:0]   o_t_out;
  logic signed [SW-1:0]   o_v_out;
  logic signed [SW-1:0]   o_f_out;
  logic signed [SW-1:0]   o_max_out;
  logic        [IDXW-1:0] o_maxidx_out;
  logic        [1:0]      o_dir_out;

  modport master (
    output i_cfg_local, i_cfg_alpha, i_cfg_beta, i_load_s, i_s_in,
    output i_valid_in, i_first_in, i_t_in, i_v_in, i_f_in, i_max_in, i_maxidx_in,
    input  o_s_out, o_load_s_out, o_valid_out, o_first_out, o_t_out,
    input  o_v_out, o_f_out, o_max_out, o_maxidx_out, o_dir_out
  );

  modport slave (
    input  i_cfg_local, i_cfg_alpha, i_cfg_beta, i_load_s, i_s_in,
    input  i_valid_in, i_first_in, i_t_in, i_v_in, i_f_in, i_max_in, i_maxidx_in,
    output o_s_out, o_load_s_out, o_valid_out, o_first_out, o_t_out,
    output o_v_out, o_f_out, o_max_out, o_maxidx_out, o_dir_out
  );
endinterface
`default_nettype wire

// File: rtl/sw_pe_affine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_pe_affine : affine-gap Smith-Waterman/NW PE, saturating, 1-cycle    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module sw_pe_affine #(
  parameter int SW       = 12,
  parameter int CW       = 2,
  parameter int IDXW     = 10,
  parameter int MATCH    = 2,
  parameter int MISMATCH = -1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  sw_pe_affine_if.slave  bus
);

  localparam int XW = SW + 2;
  localparam logic signed [SW-1:0] c_NEG_INF = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] c_POS_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [XW-1:0] c_X_NEG   = {{2{1'b1}}, c_NEG_INF};
  localparam logic signed [XW-1:0] c_X_POS   = {2'b00, c_POS_MAX};
  localparam logic signed [XW-1:0] c_X_MATCH = XW'(MATCH);
  localparam logic signed [XW-1:0] c_X_MISM  = XW'(MISMATCH);
  localparam logic [IDXW-1:0]      c_IDX_ONE = {{(IDXW-1){1'b0}}, 1'b1};
  localparam logic [1:0] c_DIR_ZERO = 2'b00;
  localparam logic [1:0] c_DIR_DIAG = 2'b01;
  localparam logic [1:0] c_DIR_UP   = 2'b10;
  localparam logic [1:0] c_DIR_LEFT = 2'b11;

  function automatic logic signed [XW-1:0] f_sext(input logic signed [SW-1:0] x);
    return {{2{x[SW-1]}}, x};
  endfunction

  function automatic logic signed [XW-1:0] f_uext(input logic [SW-1:0] x);
    return {2'b00, x};
  endfunction

  function automatic logic signed [SW-1:0] f_sat(input logic signed [XW-1:0] x);
    if (x > c_X_POS)      return c_POS_MAX;
    else if (x < c_X_NEG) return c_NEG_INF;
    else                  return x[SW-1:0];
  endfunction

  function automatic logic signed [SW-1:0] f_max(input logic signed [SW-1:0] a,
                                                 input logic signed [SW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic        [CW-1:0]   r_s;
  logic        [CW-1:0]   r_s_out;
  logic                   r_load_s_out;
  logic                   r_valid_out;
  logic                   r_first_out;
  logic        [CW-1:0]   r_t_out;
  logic signed [SW-1:0]   r_v;
  logic signed [SW-1:0]   r_f;
  logic signed [SW-1:0]   r_e;
  logic signed [SW-1:0]   r_vdiag;
  logic signed [SW-1:0]   r_max;
  logic        [IDXW-1:0] r_maxidx;
  logic        [IDXW-1:0] r_col;
  logic        [1:0]      r_dir;

  logic signed [SW-1:0]   w_vd;
  logic signed [SW-1:0]   w_eh;
  logic signed [SW-1:0]   w_vh;
  logic signed [XW-1:0]   w_sub;
  logic signed [SW-1:0]   w_e;
  logic signed [SW-1:0]   w_f;
  logic signed [SW-1:0]   w_d;
  logic signed [SW-1:0]   w_h_raw;
  logic signed [SW-1:0]   w_h;
  logic        [1:0]      w_dir;
  logic        [IDXW-1:0] w_col;
  logic                   w_max_upd;

  // A first beat starts a fresh row: no diagonal, no left gap, zero left H.
  assign w_vd  = bus.i_first_in ? '0        : r_vdiag;
  assign w_eh  = bus.i_first_in ? c_NEG_INF : r_e;
  assign w_vh  = bus.i_first_in ? '0        : r_v;
  assign w_sub = (r_s == bus.i_t_in) ? c_X_MATCH : c_X_MISM;

  assign w_e = f_max(f_sat(f_sext(w_eh) - f_uext(bus.i_cfg_beta)),
                     f_sat(f_sext(w_vh) - f_uext(bus.i_cfg_alpha)));
  assign w_f = f_max(f_sat(f_sext(bus.i_v_in) - f_uext(bus.i_cfg_alpha)),
                     f_sat(f_sext(bus.i_f_in) - f_uext(bus.i_cfg_beta)));
  assign w_d = f_sat(f_sext(w_vd) + w_sub);

  assign w_h_raw = f_max(f_max(w_d, w_f), w_e);
  assign w_h     = (bus.i_cfg_local && (w_h_raw < 0)) ? '0 : w_h_raw;

  assign w_dir = (w_d == w_h) ? c_DIR_DIAG :
                 (w_f == w_h) ? c_DIR_UP   :
                 (w_e == w_h) ? c_DIR_LEFT : c_DIR_ZERO;

  assign w_col = bus.i_first_in ? '0 :
                 (r_col == {IDXW{1'b1}}) ? r_col : r_col + c_IDX_ONE;

  // Strict compare so ties keep the upstream (earlier) position.
  assign w_max_upd = (w_h > bus.i_max_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s          <= '0;
      r_s_out      <= '0;
      r_load_s_out <= 1'b0;
      r_valid_out  <= 1'b0;
      r_first_out  <= 1'b0;
      r_t_out      <= '0;
      r_v          <= '0;
      r_f          <= c_NEG_INF;
      r_e          <= c_NEG_INF;
      r_vdiag      <= '0;
      r_max        <= '0;
      r_maxidx     <= '0;
      r_col        <= '0;
      r_dir        <= c_DIR_ZERO;
    end else begin
      r_load_s_out <= bus.i_load_s;
      r_valid_out  <= bus.i_valid_in;
      if (bus.i_load_s) begin
        r_s     <= bus.i_s_in;
        r_s_out <= r_s;
      end
      if (bus.i_valid_in) begin
        r_vdiag     <= bus.i_v_in;
        r_e         <= w_e;
        r_v         <= w_h;
        r_f         <= w_f;
        r_t_out     <= bus.i_t_in;
        r_first_out <= bus.i_first_in;
        r_col       <= w_col;
        r_dir       <= w_dir;
        if (w_max_upd) begin
          r_max    <= w_h;
          r_maxidx <= w_col;
        end else begin
          r_max    <= bus.i_max_in;
          r_maxidx <= bus.i_maxidx_in;
        end
      end
    end
  end

  assign bus.o_s_out      = r_s_out;
  assign bus.o_load_s_out = r_load_s_out;
  assign bus.o_valid_out  = r_valid_out;
  assign bus.o_first_out  = r_first_out;
  assign bus.o_t_out      = r_t_out;
  assign bus.o_v_out      = r_v;
  assign bus.o_f_out      = r_f;
  assign bus.o_max_out    = r_max;
  assign bus.o_maxidx_out = r_maxidx;
  assign bus.o_dir_out    = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_sw_pe_affine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sw_pe_affine : scoreboard bench for sw_pe_affine                    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_sw_pe_affine;
  localparam int SW = 12, CW = 2, IDXW = 10, MATCH = 2, MISMATCH = -1;
  localparam int NEG = -(1 << (SW-1));
  localparam int POS = (1 << (SW-1)) - 1;
  localparam int IDXMAX = (1 << IDXW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sw_pe_affine_if #(.SW(SW), .CW(CW), .IDXW(IDXW)) u_if ();

  sw_pe_affine #(.SW(SW), .CW(CW), .IDXW(IDXW), .MATCH(MATCH), .MISMATCH(MISMATCH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  typedef struct {
    int v; int f; int mx; int idx; int dir; int t; int first;
  } exp_t;

  exp_t q[$];
  exp_t m_last;
  int m_s, m_sout, m_h, m_e, m_vdiag, m_col;
  int cfg_local, cfg_alpha, cfg_beta;
  int n_pass = 0;
  int n_tot  = 0;

  function automatic int sat(input int x);
    if (x > POS) return POS;
    if (x < NEG) return NEG;
    return x;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
  endtask

  task automatic m_reset();
    m_s = 0; m_sout = 0; m_h = 0; m_e = NEG; m_vdiag = 0; m_col = 0;
    m_last = '{v: 0, f: NEG, mx: 0, idx: 0, dir: 0, t: 0, first: 0};
  endtask

  // Reference cell: the recurrence written directly on integers.
  task automatic beat(input bit first, input int t, input int v, input int f,
                      input int mx, input int mi, input bit ld = 1'b0, input int sin = 0);
    exp_t e;
    int vd, eh, vh, sub, ee, ff, dd, hh, col;
    @(negedge clk);
    u_if.i_valid_in  = 1'b1;
    u_if.i_first_in  = first;
    u_if.i_t_in      = CW'(t);
    u_if.i_v_in      = SW'(v);
    u_if.i_f_in      = SW'(f);
    u_if.i_max_in    = SW'(mx);
    u_if.i_maxidx_in = IDXW'(mi);
    u_if.i_load_s    = ld;
    u_if.i_s_in      = CW'(sin);
    vd  = first ? 0   : m_vdiag;
    eh  = first ? NEG : m_e;
    vh  = first ? 0   : m_h;
    sub = (m_s == t) ? MATCH : MISMATCH;
    ee  = imax(sat(eh - cfg_beta), sat(vh - cfg_alpha));
    ff  = imax(sat(v - cfg_alpha), sat(f - cfg_beta));
    dd  = sat(vd + sub);
    hh  = imax(imax(dd, ff), ee);
    if (cfg_local != 0) hh = imax(hh, 0);
    col = first ? 0 : ((m_col < IDXMAX) ? m_col + 1 : IDXMAX);
    e.v = hh; e.f = ff; e.t = t; e.first = first;
    e.dir = (dd == hh) ? 1 : (ff == hh) ? 2 : (ee == hh) ? 3 : 0;
    if (hh > mx) begin e.mx = hh; e.idx = col; end
    else begin e.mx = mx; e.idx = mi; end
    q.push_back(e);
    m_last = e;
    m_vdiag = v; m_e = ee; m_h = hh; m_col = col;
    if (ld) begin m_sout = m_s; m_s = sin; end
  endtask

  task automatic idle();
    @(negedge clk);
    u_if.i_valid_in = 1'b0;
    u_if.i_load_s   = 1'b0;
  endtask

  task automatic load(input int s);
    @(negedge clk);
    u_if.i_valid_in = 1'b0;
    u_if.i_load_s   = 1'b1;
    u_if.i_s_in     = CW'(s);
    m_sout = m_s; m_s = s;
  endtask

  task automatic setcfg(input int loc, input int a, input int b);
    @(negedge clk);
    u_if.i_valid_in  = 1'b0;
    u_if.i_load_s    = 1'b0;
    cfg_local = loc; cfg_alpha = a; cfg_beta = b;
    u_if.i_cfg_local = (loc != 0);
    u_if.i_cfg_alpha = SW'(a);
    u_if.i_cfg_beta  = SW'(b);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_hold(input string nm);
    chk({nm, "_valid"}, int'(u_if.o_valid_out), 0);
    chk({nm, "_v"},     int'(u_if.o_v_out),     m_last.v);
    chk({nm, "_f"},     int'(u_if.o_f_out),     m_last.f);
    chk({nm, "_max"},   int'(u_if.o_max_out),   m_last.mx);
    chk({nm, "_dir"},   int'(u_if.o_dir_out),   m_last.dir);
    chk({nm, "_sout"},  int'(u_if.o_s_out),     m_sout);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (u_if.o_valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_v",     int'(u_if.o_v_out),      e.v);
          chk("sb_f",     int'(u_if.o_f_out),      e.f);
          chk("sb_max",   int'(u_if.o_max_out),    e.mx);
          chk("sb_idx",   int'(u_if.o_maxidx_out), e.idx);
          chk("sb_dir",   int'(u_if.o_dir_out),    e.dir);
          chk("sb_t",     int'(u_if.o_t_out),      e.t);
          chk("sb_first", int'(u_if.o_first_out),  e.first);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    int len, lo;
    rst_n = 1'b0;
    u_if.i_valid_in = 0; u_if.i_first_in = 0; u_if.i_load_s = 0; u_if.i_s_in = 0;
    u_if.i_t_in = 0; u_if.i_v_in = 0; u_if.i_f_in = 0; u_if.i_max_in = 0; u_if.i_maxidx_in = 0;
    cfg_local = 1; cfg_alpha = 7; cfg_beta = 3;
    u_if.i_cfg_local = 1'b1; u_if.i_cfg_alpha = SW'(7); u_if.i_cfg_beta = SW'(3);
    m_reset();
    #12;
    chk("rst_v",     int'(u_if.o_v_out),       0);
    chk("rst_f",     int'(u_if.o_f_out),       NEG);
    chk("rst_valid", int'(u_if.o_valid_out),   0);
    chk("rst_max",   int'(u_if.o_max_out),     0);
    chk("rst_dir",   int'(u_if.o_dir_out),     0);
    chk("rst_lso",   int'(u_if.o_load_s_out),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: match on a first beat, local mode
    load(2);
    settle();
    chk("load_s_out", int'(u_if.o_load_s_out), 1);
    beat(1, 2, 0, NEG, 0, 0);
    settle();
    chk("t1_v", int'(u_if.o_v_out), 2);
    chk("t1_f", int'(u_if.o_f_out), -7);
    chk("t1_dir", int'(u_if.o_dir_out), 1);
    chk("t1_col", int'(u_if.o_maxidx_out), 0);

    // Test 2: mismatch, local clamps to zero; global goes negative
    beat(1, 1, 0, NEG, 0, 0);
    settle();
    chk("t2_loc_v", int'(u_if.o_v_out), 0);
    chk("t2_loc_dir", int'(u_if.o_dir_out), 0);
    setcfg(0, 7, 3);
    beat(1, 1, 0, NEG, 0, 0);
    settle();
    chk("t2_glb_v", int'(u_if.o_v_out), -1);
    chk("t2_glb_dir", int'(u_if.o_dir_out), 1);
    setcfg(1, 7, 3);

    // Test 3: positive and negative saturation
    beat(1, 2, POS, NEG, 0, 0);
    beat(0, 2, 0, NEG, 0, 0);
    settle();
    chk("t3_sat_v", int'(u_if.o_v_out), POS);
    beat(0, 1, NEG, NEG, 0, 0);
    settle();
    chk("t3_sat_f", int'(u_if.o_f_out), NEG);

    // Test 4: max tracking with a tie that keeps upstream
    beat(1, 2, 3, NEG, 5, 3);
    settle();
    chk("t4_a_max", int'(u_if.o_max_out), 5);
    chk("t4_a_idx", int'(u_if.o_maxidx_out), 3);
    beat(0, 2, 4, NEG, 5, 3);
    settle();
    chk("t4_tie_idx", int'(u_if.o_maxidx_out), 3);
    beat(0, 2, 0, NEG, 5, 3);
    settle();
    chk("t4_new_max", int'(u_if.o_max_out), 6);
    chk("t4_new_idx", int'(u_if.o_maxidx_out), 2);

    // Test 5: three-cycle stall mid-stream, then resume
    beat(0, 0, 1, -3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      settle();
      chk_hold("t5_stall");
    end
    beat(0, 2, 2, -1, 0, 0);
    beat(0, 3, -4, 0, 0, 0);

    // Randomised sequences with stalls, reloads and config changes
    for (int s = 0; s < 40; s++) begin
      idle();
      setcfg(int'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? POS : int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) == 0) ? POS : int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, 3)));
      len = int'($urandom_range(1, 20));
      for (int b = 0; b < len; b++) begin
        lo = ($urandom_range(0, 7) == 0) ? 1 : 0;
        beat(b == 0, int'($urandom_range(0, 3)),
             lo ? int'($urandom_range(0, 4095)) + NEG : int'($urandom_range(0, 60)) - 30,
             lo ? int'($urandom_range(0, 4095)) + NEG : int'($urandom_range(0, 60)) - 30,
             int'($urandom_range(0, 40)) - 10, int'($urandom_range(0, IDXMAX)),
             $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
        if ($urandom_range(0, 7) == 0) begin
          idle();
          settle();
          chk_hold("rnd_stall");
        end
      end
    end

    // Test 6: asynchronous reset mid-stream, then reload the query chain
    idle();
    setcfg(1, 7, 3);
    beat(1, 1, 5, 2, 0, 0);
    beat(0, 2, 6, 1, 0, 0);
    @(posedge clk);
    #3;
    u_if.i_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", int'(u_if.o_v_out), 0);
    chk("t6_rst_f", int'(u_if.o_f_out), NEG);
    chk("t6_rst_valid", int'(u_if.o_valid_out), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load(1);
    load(3);
    settle();
    chk("t6_s_out", int'(u_if.o_s_out), 1);
    beat(1, 3, 0, NEG, 0, 0);
    settle();
    chk("t6_s_reg_match_v", int'(u_if.o_v_out), 2);
    idle();

    for (int w = 0; w < 10 && q.size() != 0; w++) settle();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
`default_nettype wire
